// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Handles unsigned and signed (truncating) division with a fixed
// WIDTH+1 edge latency from start to result, including divide by zero.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] rm,
    input  logic             mode,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [5:0]       r_count;
    logic [WIDTH-1:0] r_quo;      // dividend bits shifted out, quotient bits shifted in
    logic [WIDTH-1:0] r_part;     // partial remainder
    logic [WIDTH-1:0] r_div;      // divisor magnitude
    logic [WIDTH-1:0] r_rn;       // original dividend, returned as rem on divide by zero
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_rem;

    logic             w_load;
    logic             w_last;
    logic [WIDTH-1:0] w_rn_mag;
    logic [WIDTH-1:0] w_rm_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_part_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_y_final;
    logic [WIDTH-1:0] w_rem_final;

    // Operands are only accepted outside RUN, so a running division is never disturbed.
    assign w_load   = start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_count == LAST_STEP);
    assign w_rn_mag = (mode && rn[WIDTH-1]) ? -rn : rn;
    assign w_rm_mag = (mode && rm[WIDTH-1]) ? -rm : rm;

    // One restoring step: the partial remainder stays below the divisor, so the
    // difference always fits in WIDTH bits when the subtraction is taken.
    assign w_shift     = {r_part, r_quo[WIDTH-1]};
    assign w_ge        = w_shift >= {1'b0, r_div};
    assign w_sub       = w_shift[WIDTH-1:0] - r_div;
    assign w_part_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_ge};

    // Sign correction of the final step, with divide by zero forced to y=0, rem=rn.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_y_final   = w_quo_next;
        w_rem_final = w_part_next;
        if (r_div == '0) begin
            w_y_final   = '0;
            w_rem_final = r_rn;
        end else begin
            if (r_neg_q) w_y_final   = -w_quo_next;
            if (r_neg_r) w_rem_final = -w_part_next;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: IDLE -> RUN on start, RUN for WIDTH steps, DONE for one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture operands on load, iterate in RUN, publish results on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_quo   <= '0;
            r_part  <= '0;
            r_div   <= '0;
            r_rn    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_y     <= '0;
            r_rem   <= '0;
        end else if (w_load) begin
            r_count <= '0;
            r_quo   <= w_rn_mag;
            r_part  <= '0;
            r_div   <= w_rm_mag;
            r_rn    <= rn;
            r_neg_q <= mode && (rn[WIDTH-1] ^ rm[WIDTH-1]);
            r_neg_r <= mode && rn[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_count <= r_count + 6'd1;
            r_quo   <= w_quo_next;
            r_part  <= w_part_next;
            if (w_last) begin
                r_y   <= w_y_final;
                r_rem <= w_rem_final;
            end
        end
    end

    assign y    = r_y;
    assign rem  = r_rem;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, unsigned/signed results, corner cases,
// start handshake, reset during a run, and a short randomized sweep.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        mode;
    logic [31:0] y;
    logic [31:0] rem;
    logic        busy;
    logic        done;

    int n_vec;
    int n_err;

    seq_divider #(.WIDTH(32)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .rn   (rn),
        .rm   (rm),
        .mode (mode),
        .y    (y),
        .rem  (rem),
        .busy (busy),
        .done (done)
    );

    // 10-unit clock; stimulus and sampling happen on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference division built from the language operators.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic m, output logic [31:0] q,
                                    output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'd0;
            r = a;
        end else if (!m) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Present one start pulse; returns on the falling edge just after the capture edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m);
        @(negedge clk);
        start = 1'b1;
        rn    = a;
        rm    = b;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; checks latency, busy/held outputs during RUN and results.
    // If inj >= 0 a second start with other operands is pulsed at that RUN cycle.
    task automatic wait_done(input string name, input logic [31:0] ey,
                             input logic [31:0] er, input int inj);
        int          cyc;
        logic        run_bad;
        logic [31:0] y0;
        logic [31:0] r0;
        cyc     = 0;
        run_bad = 1'b0;
        y0      = y;
        r0      = rem;
        while (done !== 1'b1 && cyc < 40) begin
            if (inj >= 0 && cyc == inj) begin
                start = 1'b1;
                rn    = 32'd50;
                rm    = 32'd5;
                mode  = 1'b0;
            end else if (inj >= 0 && cyc == inj + 1) begin
                start = 1'b0;
            end
            if (busy !== 1'b1 || y !== y0 || rem !== r0) run_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc !== 32) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, expected 32", name, cyc);
        end
        n_vec++;
        if (run_bad !== 1'b0) begin
            n_err++;
            $display("FAIL %s run: busy low or y/rem changed during RUN", name);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_at_done: got %b, expected 0", name, busy);
        end
        n_vec++;
        if (y !== ey) begin
            n_err++;
            $display("FAIL %s y: got %h, expected %h", name, y, ey);
        end
        n_vec++;
        if (rem !== er) begin
            n_err++;
            $display("FAIL %s rem: got %h, expected %h", name, rem, er);
        end
    endtask

    // Done must be a single-cycle pulse.
    task automatic end_pulse(input string name);
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_width: got done=%b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic m, input logic [31:0] ey, input logic [31:0] er);
        start_op(a, b, m);
        wait_done(name, ey, er, -1);
        end_pulse(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        rn    = 32'd0;
        rm    = 32'd0;
        mode  = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (y !== 32'd0 || rem !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got y=%h rem=%h, expected 0/0", y, rem);
        end
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%b done=%b, expected 0/0", busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_unsigned();
        run_div("u_100_7",      32'd100,        32'd7,  1'b0, 32'd14,        32'd2);
        run_div("u_7_100",      32'd7,          32'd100, 1'b0, 32'd0,        32'd7);
        run_div("u_neg100_7",   32'hFFFF_FF9C,  32'd7,  1'b0, 32'h2492_4916, 32'd2);
    endtask

    task automatic test_signed();
        run_div("s_m100_7",     32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run_div("s_100_m7",     32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2, 32'd2);
        run_div("s_m100_m7",    32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,        32'hFFFF_FFFE);
    endtask

    task automatic test_corners();
        run_div("u_div0",       32'h1234_5678,  32'd0,          1'b0, 32'd0,         32'h1234_5678);
        run_div("s_div0",       32'hFFFF_FF9C,  32'd0,          1'b1, 32'd0,         32'hFFFF_FF9C);
        run_div("s_overflow",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0);
        run_div("u_max_1",      32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0);
        run_div("u_zero_rn",    32'd0,          32'd5,          1'b0, 32'd0,         32'd0);
        run_div("s_zero_rn",    32'd0,          32'hFFFF_FFFB,  1'b1, 32'd0,         32'd0);
    endtask

    task automatic test_ignore_start();
        start_op(32'd1000, 32'd3, 1'b0);
        wait_done("ignore_start", 32'd333, 32'd1, 10);
        end_pulse("ignore_start");
    endtask

    task automatic test_back_to_back();
        start_op(32'd1000, 32'd3, 1'b0);
        wait_done("b2b_first", 32'd333, 32'd1, -1);
        // Start held in the DONE cycle: the next edge must launch the second run.
        start = 1'b1;
        rn    = 32'hFFFF_FFFF;
        rm    = 32'h0000_0010;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_relaunch: got done=%b busy=%b, expected 0/1", done, busy);
        end
        wait_done("b2b_second", 32'h0FFF_FFFF, 32'h0000_000F, -1);
        end_pulse("b2b_second");
    endtask

    task automatic test_reset_in_run();
        logic seen;
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_run_flags: got busy=%b done=%b, expected 0/0", busy, done);
        end
        n_vec++;
        if (y !== 32'd0 || rem !== 32'd0) begin
            n_err++;
            $display("FAIL rst_run_outputs: got y=%h rem=%h, expected 0/0", y, rem);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_run_abandon: got activity after reset, expected none");
        end
        run_div("after_reset", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        m;
        for (int i = 0; i < 48; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 11 == 5) b = 32'd0;
            m = i[0];
            ref_div(a, b, m, eq, er);
            run_div("random", a, b, m, eq, er);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_in_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, setting the operand and result width; all behaviour below is stated for WIDTH=32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new division; sampled at the rising edge.
REQ-005 SHALL have port rn, input, WIDTH bits: dividend; captured with start.
REQ-006 SHALL have port rm, input, WIDTH bits: divisor; captured with start.
REQ-007 SHALL have port mode, input, 1 bit: 0 = unsigned (UDIV), 1 = signed (SDIV); captured with start.
REQ-008 SHALL have port y, output, WIDTH bits: quotient, feeding the datapath DIVResult path.
REQ-009 SHALL have port rem, output, WIDTH bits: remainder.
REQ-010 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking y/rem valid.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE, plus a 6-bit iteration counter.
REQ-013 IDLE: if start=1 at edge N, SHALL capture rn, rm and mode, load |rn| and |rm| (magnitudes only when mode=1), clear the counter and enter RUN; otherwise SHALL stay in IDLE.
REQ-014 RUN: each edge SHALL perform one restoring shift-subtract step, producing 1 quotient bit MSB-first, and increment the counter.
REQ-015 After the 32nd step (edge N+32), SHALL update y/rem with the sign-corrected results and enter DONE.
REQ-016 Fixed latency: done=1 exactly in the cycle following edge N+32, for one cycle only.
REQ-017 DONE: next edge SHALL return to IDLE; if start=1 at that edge, SHALL instead capture new operands and enter RUN (back-to-back operation, no idle bubble).
REQ-018 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-019 start SHALL be ignored while in RUN; captured operands SHALL NOT change mid-operation.
REQ-020 y and rem SHALL hold their last result until the next completion; they SHALL NOT show intermediate values during RUN.
REQ-021 Unsigned mode: y = floor(rn/rm), rem = rn - y*rm.
REQ-022 Signed mode: quotient truncated toward zero; sign(y) = sign(rn) XOR sign(rm); rem carries sign of rn; |rem| < |rm|.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give y=0x80000000, rem=0.
REQ-024 Divide by zero (rm=0), either mode: SHALL keep the same 33-edge latency and produce y=0 and rem=rn; no flag or exception.
REQ-025 rn=0 SHALL give y=0, rem=0 for any nonzero rm.

Reset
REQ-026 reset=1 at an edge SHALL force state IDLE, counter 0, y=0, rem=0, busy=0, done=0, regardless of state; it takes priority over start.
REQ-027 Reset asserted during RUN SHALL abandon the operation; no done pulse follows.
REQ-028 After reset deasserts, the first start SHALL behave exactly as in REQ-013.

Verification
REQ-029 Unsigned: start with rn=100, rm=7, mode=0 -> busy=1 for 32 cycles, then done pulse, y=14, rem=2.
REQ-030 Signed: rn=-100 (0xFFFFFF9C), rm=7, mode=1 -> y=-14 (0xFFFFFFF2), rem=-2 (0xFFFFFFFE); rn=100, rm=-7 -> y=-14, rem=2.
REQ-031 Corners: rm=0, rn=0x12345678 -> y=0, rem=0x12345678 after 33 edges; 0x80000000 / 0xFFFFFFFF in signed mode -> y=0x80000000, rem=0; 0xFFFFFFFF / 1 in unsigned mode -> y=0xFFFFFFFF, rem=0.
REQ-032 Handshake: start pulsed again at RUN cycle 10 with different operands -> ignored, first result unchanged; start held high in the DONE cycle -> second operation begins, done pulses again 33 edges later.
REQ-033 Reset: reset=1 at RUN cycle 15 -> next cycle busy=0, done=0, y=0, rem=0, and no done pulse ever follows for that operation.
REQ-034 Random: 10k random operand pairs in both modes checked against a reference model; done width is exactly 1 cycle every time.
